// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host command path.
//   ctrl_state_e : command sequencer states (S_IDLE is the reset state)
//   bus_state_e  : Wishbone slave access states
//   PS2_CMD_* / PS2_RESP_* : well-known keyboard command and response bytes
//   odd_parity() : PS/2 frame parity bit for a data byte
package ps2_pkg;

  typedef enum bit [3:0] {
    S_IDLE    = 4'd0,
    S_INHIBIT = 4'd1,
    S_START   = 4'd2,
    S_SHIFT   = 4'd3,
    S_ACK     = 4'd4,
    S_RESP    = 4'd5
  } ctrl_state_e;

  typedef enum bit [3:0] {
    S_BIDLE = 4'd0,
    S_BBUSY = 4'd1,
    S_BDONE = 4'd2
  } bus_state_e;

  localparam logic [7:0] PS2_CMD_LEDS    = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RESP_BAT    = 8'hAA;

  // The PS/2 parity bit makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/if_wb.sv
// if_wb: minimal 32-bit Wishbone classic bundle.
//   cyc, stb, we, adr, dat_w : master -> slave
//   dat_r, ack, stall        : slave -> master
// Handshake: a transfer is requested while cyc&stb are high; the master
// holds adr/we/dat_w stable until it sees ack (one cycle wide), then drops
// stb; dat_r is valid in the ack cycle.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack, stall);
  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack, stall);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 3-flop synchronizer for a raw PS/2 pin plus edge detect.
//   clk, rst : system clock, async active-high reset
//   pin      : raw asynchronous pin
//   level    : synchronized pin level
//   rise     : one-cycle strobe on synchronized 0->1
//   fall     : one-cycle strobe on synchronized 1->0
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic       prev_q;

  // Idle PS/2 lines are high, so reset to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b111;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[1:0], pin};
      prev_q <= sync_q[2];
    end
  end

  assign level = sync_q[2];
  assign rise  = ~prev_q & sync_q[2];
  assign fall  = prev_q & ~sync_q[2];

endmodule

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: PS/2 host-to-device command sequencer with Wishbone slave.
//   clk_i, rst_i          : system clock, async active-high reset
//   bus                   : Wishbone slave; adr[2]=0 cmd/resp, adr[2]=1 status
//                           status = {busy, ack_err, timeout, resp_valid}
//   ps2_clock_i/ps2_data_i: raw PS/2 pins
//   ps2_clock_oe/data_oe  : 1 = pull the line low (open drain)
//   rx_valid, rx_data     : decoded byte strobe from the receive path
//   rx_hold               : 1 = receive path discards frames in progress
//   ctrl_state            : current sequencer state (debug)
// Build option: define PS2_HOST_RETRY_EN to automatically re-send the
// command when the keyboard answers 0xFE (up to 3 retries).
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_wb.slave         bus,
  input  logic        ps2_clock_i,
  input  logic        ps2_data_i,
  output logic        ps2_clock_oe,
  output logic        ps2_data_oe,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_hold,
  output ctrl_state_e ctrl_state
);

  localparam longint INHIBIT_CYC = longint'(CLK_HZ) / 1000000 * longint'(INHIBIT_US);
  localparam longint TIMEOUT_CYC = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 1000;
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  ctrl_state_e   state;
  bus_state_e    bstate;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    cmd;
  logic [7:0]    resp;
  logic          resp_valid, ack_err, timeout;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          clk_fall, data_level, tx_bit, cmd_wr, busy;
  logic [3:0]    status;
  logic          clk_level_unused, clk_rise_unused, data_rise_unused, data_fall_unused;
  logic          bus_unused;
`ifdef PS2_HOST_RETRY_EN
  logic [1:0]    retry_cnt;
`endif

  ps2_sync_edge u_clk_sync (
    .clk(clk_i), .rst(rst_i), .pin(ps2_clock_i),
    .level(clk_level_unused), .rise(clk_rise_unused), .fall(clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk(clk_i), .rst(rst_i), .pin(ps2_data_i),
    .level(data_level), .rise(data_rise_unused), .fall(data_fall_unused)
  );

  assign busy       = (state != S_IDLE);
  assign status     = {busy, ack_err, timeout, resp_valid};
  assign ctrl_state = state;
  assign cmd_wr     = (bstate == S_BBUSY) && bus.we && !bus.adr[2];
  assign bus.ack    = ack_q;
  assign bus.dat_r  = dat_q;
  assign bus.stall  = 1'b0;
  assign bus_unused = ^{bus.adr[31:3], bus.adr[1:0], bus.dat_w[31:8], bus.cyc & 1'b0};

  // Bit presented after fall number bit_cnt: d0..d7, parity, then stop (released).
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt < 4'd8)       tx_bit = cmd[bit_cnt[2:0]];
    else if (bit_cnt == 4'd8) tx_bit = odd_parity(cmd);
  end

  // Bus access: sample in S_BIDLE, act in S_BBUSY, ack in S_BDONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bstate <= S_BIDLE;
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
    end else begin
      case (bstate)
        S_BIDLE: begin
          ack_q <= 1'b0;
          if (bus.cyc && bus.stb) bstate <= S_BBUSY;
        end
        S_BBUSY: begin
          bstate <= S_BDONE;
          ack_q  <= 1'b1;
          dat_q  <= bus.adr[2] ? {28'h0, status} : {24'h0, resp};
        end
        S_BDONE: begin
          bstate <= S_BIDLE;
          ack_q  <= 1'b0;
        end
        default: begin
          bstate <= S_BIDLE;
          ack_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      inh_cnt      <= '0;
      tmo_cnt      <= '0;
      bit_cnt      <= 4'd0;
      cmd          <= 8'h00;
      resp         <= 8'h00;
      resp_valid   <= 1'b0;
      ack_err      <= 1'b0;
      timeout      <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      rx_hold      <= 1'b0;
`ifdef PS2_HOST_RETRY_EN
      retry_cnt    <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_wr) begin
            cmd          <= bus.dat_w[7:0];
            ack_err      <= 1'b0;
            timeout      <= 1'b0;
            resp_valid   <= 1'b0;
            state        <= S_INHIBIT;
            ps2_clock_oe <= 1'b1;
            rx_hold      <= 1'b1;
            inh_cnt      <= INH_LOAD;
`ifdef PS2_HOST_RETRY_EN
            retry_cnt    <= 2'd0;
`endif
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == '0) begin
            // Start bit goes out as the clock is released.
            state        <= S_START;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b1;
            tmo_cnt      <= TMO_LOAD;
          end else begin
            inh_cnt <= inh_cnt - IW'(1);
          end
        end
        S_START: begin
          state   <= S_SHIFT;
          bit_cnt <= 4'd0;
        end
        S_SHIFT: begin
          if (clk_fall) begin
            ps2_data_oe <= ~tx_bit;
            bit_cnt     <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) state <= S_ACK;
          end
        end
        S_ACK: begin
          ps2_data_oe <= 1'b0;
          if (clk_fall) begin
            rx_hold <= 1'b0;
            if (!data_level) begin
              state <= S_RESP;
            end else begin
              ack_err <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end
        S_RESP: begin
          if (rx_valid) begin
`ifdef PS2_HOST_RETRY_EN
            if (rx_data == PS2_RESP_RESEND && retry_cnt != 2'd3) begin
              retry_cnt    <= retry_cnt + 2'd1;
              state        <= S_INHIBIT;
              ps2_clock_oe <= 1'b1;
              rx_hold      <= 1'b1;
              inh_cnt      <= INH_LOAD;
            end else
`endif
            begin
              resp       <= rx_data;
              resp_valid <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Timeout overrides the state actions above, except that a response
      // arriving on the expiry cycle is still accepted.
      if (state == S_START || state == S_SHIFT || state == S_ACK || state == S_RESP) begin
        if (tmo_cnt == '0) begin
          if (!(state == S_RESP && rx_valid)) begin
            timeout      <= 1'b1;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            rx_hold      <= 1'b0;
            state        <= S_IDLE;
          end
        end else begin
          tmo_cnt <= tmo_cnt - TW'(1);
        end
      end
    end
  end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
Host-to-device command sequencer for the PS/2 keyboard port. Takes one command byte from the Wishbone bus (e.g. 0xED set LEDs, 0xFF reset). Runs the PS/2 host-request protocol on open-drain clock/data enables, then captures the keyboard's response byte from the existing receive datapath. During a transmit it holds the receive path off so that partial frames are discarded.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
INHIBIT_US, 100, duration PS/2 clock is held low before the start bit, in µs
TIMEOUT_MS, 15, maximum time from clock release to response byte, in ms

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
bus  if_wb.slave  -  Wishbone slave; 32-bit data; decode on adr[2]; stall tied 0
ps2_clock_i  in  1  raw PS/2 clock pin
ps2_data_i  in  1  raw PS/2 data pin
ps2_clock_oe  out  1  1 = drive PS/2 clock low
ps2_data_oe  out  1  1 = drive PS/2 data low
rx_valid  in  1  one-cycle strobe: byte decoded by the receive path
rx_data  in  8  decoded byte, valid with rx_valid
rx_hold  out  1  1 = receive path must discard frames in progress

Behaviour:
- Reset (async): all outputs 0, both lines released, state S_IDLE, status and response registers cleared.
- Input conditioning: both pins go through a 3-flop synchronizer. ps2_fall = synced clock 1→0.
- Bus access:
  - cyc&stb is sampled in S_BIDLE, ack follows 2 cycles later (S_BBUSY→S_BDONE), one cycle wide.
  - Write adr[2]=0: load cmd[7:0] from dat[7:0]. If ctrl state is S_IDLE, start a transaction and clear the err, timeout and resp_valid flags. If a transaction is in progress, the write is ignored but still acked.
  - Read adr[2]=0: returns {24'h0, resp}.
  - Read adr[2]=1: returns {28'h0, busy, ack_err, timeout, resp_valid}.
  - Write to adr[2]=1: no effect.
- Control FSM:
  - S_IDLE: lines released, rx_hold=0.
  - S_INHIBIT: clock_oe=1, rx_hold=1, for CLK_HZ/1e6*INHIBIT_US cycles (5000 at default).
  - S_START: data_oe=1, clock_oe=0. Start the timeout counter (TIMEOUT_MS*CLK_HZ/1000 cycles; width by $clog2). Go to S_SHIFT.
  - S_SHIFT: on each ps2_fall, present the next bit on data_oe = ~bit. Order: d0..d7, then odd parity (~^cmd), then stop (release). The 4-bit bit counter runs 0..9; after the 10th fall → S_ACK.
  - S_ACK: data_oe=0. Sample synced data on the next ps2_fall. If 0 → S_RESP; if 1 → set ack_err, go to S_IDLE.
  - S_RESP: rx_hold=0. The first rx_valid stores rx_data into resp and sets resp_valid → S_IDLE.
- Timeout: if the counter expires in any of S_START..S_RESP, set timeout, release both lines, go to S_IDLE. A response arriving on the same cycle as expiry wins.
- busy = (state != S_IDLE).
- rx_valid outside S_RESP is ignored.
- Reset mid-transaction releases both lines immediately.

Optional Feature:
PS2_HOST_RETRY_EN.
- Defined: if the response is 0xFE (resend), the same cmd is re-sent from S_INHIBIT automatically, up to 3 retries (2-bit counter). After the 3rd retry 0xFE is stored as resp and resp_valid is set. Timeout is re-armed on each retry.
- Undefined: 0xFE is stored like any other response.

Decomposition:
- Package ps2_pkg: ctrl and bus state enums as bit[3:0]; constants PS2_CMD_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_RESP_ACK=8'hFA, PS2_RESP_RESEND=8'hFE, PS2_RESP_BAT=8'hAA.
- Sub-module ps2_sync_edge: synchronizer plus rise/fall detect, reusable by the receiver.

Test Plan:
1. Write 0xED, device model clocks 11 edges and ACKs → clock held low exactly 5000 cycles; data bits observed 1,0,1,1,0,1,1,1 with parity 1; status busy=1 until done.
2. Continue from scenario 1: model sends 0xFA on rx_valid → resp reads 0x000000FA; status = 4'b0001; rx_hold low.
3. Device never clocks after clock release → after 750000 cycles status = 4'b0010; both oe=0.
4. Device leaves data high in the ACK slot → status = 4'b0100; no resp captured.
5. Write 0xFF while busy → acked, cmd unchanged, transaction completes with the original byte; async reset during S_SHIFT → oe=0 in the same cycle.
6. Retry (PS2_HOST_RETRY_EN): model answers 0xFE twice, then 0xFA → 3 transmissions of the cmd observed; resp=0xFA. Without the macro: resp=0xFE after 1 transmission.
